// File: rtl/arm_mc_controller.sv
`default_nettype none
// ============================================================================
// arm_mc_controller : multicycle ARM control unit (FSM, NZCV flags, cond codes)
// Revision: 1.0
// ============================================================================
module arm_mc_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ALUCTRL_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q, flags_d;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic        i_bit;
  logic [3:0]  cmd;
  logic        s_bit;
  logic        u_bit;
  logic [3:0]  rd;
  logic        rd_is_pc;
  logic        mem_rdy;
  logic        unused_instr;

  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign i_bit        = Instr[13];
  assign cmd          = Instr[12:9];
  assign s_bit        = Instr[8];
  assign u_bit        = Instr[11];
  assign rd           = Instr[7:4];
  assign rd_is_pc     = (rd == 4'hF);
  assign unused_instr = ^Instr[3:0];
  assign mem_rdy      = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  // Data-processing command decode: unsupported opcodes fall back to ADD
  logic       cmd_ok;
  logic       cmd_arith;
  logic [1:0] cmd_alu;

  always_comb begin
    cmd_ok    = 1'b1;
    cmd_arith = 1'b0;
    cmd_alu   = 2'b00;
    case (cmd)
      4'b0100: begin cmd_alu = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = 2'b01; cmd_arith = 1'b1; end
      4'b0000: cmd_alu = 2'b10;
      4'b1100: cmd_alu = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
  end

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~(flag_c & ~flag_z);
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = ~(~flag_z & (flag_n == flag_v));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ex) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        state_d = S_ALUWB;
        // Logical ops leave carry and overflow untouched
        if (s_bit && cmd_ok) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (cmd_arith) flags_d[1:0] = ALUFlags[1:0];
        end
      end
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: state_d = s_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  logic [1:0] alu_ctl;

  // Reset low forces every control output to 0 regardless of state
  always_comb begin
    MemReq    = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_ctl   = 2'b00;
    ImmSrc    = op;
    RegSrc    = {(op == 2'b01) & ~s_bit, (op == 2'b10)};
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        IRWrite   = mem_rdy;
        PCWrite   = mem_rdy;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_EXECR: alu_ctl = cmd_alu;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_ctl = cmd_alu;
      end
      S_ALUWB: begin
        RegWrite = cmd_ok & ~rd_is_pc;
        PCWrite  = cmd_ok & rd_is_pc;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        alu_ctl = u_bit ? 2'b00 : 2'b01;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = ~rd_is_pc;
        PCWrite   = rd_is_pc;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_rdy;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      MemReq    = 1'b0;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      alu_ctl   = 2'b00;
      ImmSrc    = 2'b00;
      RegSrc    = 2'b00;
    end
  end

  generate
    if (ALUCTRL_W > 2) begin : g_alu_wide
      assign ALUControl = {{(ALUCTRL_W-2){1'b0}}, alu_ctl};
    end else begin : g_alu_narrow
      assign ALUControl = alu_ctl;
    end
  endgenerate

  assign Flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
`default_nettype none
// ============================================================================
// tb_arm_mc_controller : directed cycle-by-cycle bench for arm_mc_controller
// Revision: 1.0
// ============================================================================
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        MemReq, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags;

  int checks   = 0;
  int failures = 0;

  // {MemReq, IRWrite, PCWrite, MemWrite, RegWrite}
  logic [4:0] strb;
  // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
  logic [7:0] mux;
  assign strb = {MemReq, IRWrite, PCWrite, MemWrite, RegWrite};
  assign mux  = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};

  localparam logic [7:0] M_FD   = 8'h68;
  localparam logic [7:0] M_EXR  = 8'h00;
  localparam logic [7:0] M_ORR  = 8'h03;
  localparam logic [7:0] M_ADDI = 8'h10;
  localparam logic [7:0] M_SUBI = 8'h11;
  localparam logic [7:0] M_MEM  = 8'h80;
  localparam logic [7:0] M_MWB  = 8'h04;
  localparam logic [7:0] M_BR   = 8'h18;

  arm_mc_controller #(.MEM_HANDSHAKE(1), .ALUCTRL_W(2)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .MemReq(MemReq), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemReady = 1'b1; Instr = 20'hE0821; ALUFlags = 4'hF;
    step(); step();
    checks++;
    if (strb !== 5'b0 || mux !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs strb=%b mux=%h expected 0/00", strb, mux);
    end
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b expected=0000", Flags);
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    logic [4:0] es [5];
    logic [7:0] em [5];
    logic       rd [5];
    es = '{5'b11100, 5'b00000, 5'b00000, 5'b00001, 5'b10000};
    em = '{M_FD, M_FD, M_EXR, M_EXR, M_FD};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Instr = 20'hE0821; ALUFlags = 4'hF;
    for (int i = 0; i < 5; i++) begin
      MemReady = rd[i]; #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL add_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL add_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL add_flags got=%b exp=0000", Flags); end
  endtask

  task automatic test_ldr();
    logic [4:0] es [10];
    logic [7:0] em [10];
    logic       rd [10];
    es = '{5'b10000, 5'b10000, 5'b11100, 5'b00000, 5'b00000,
           5'b10000, 5'b10000, 5'b10000, 5'b00001, 5'b10000};
    em = '{M_FD, M_FD, M_FD, M_FD, M_ADDI, M_MEM, M_MEM, M_MEM, M_MWB, M_FD};
    rd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    Instr = 20'hE5921;
    for (int i = 0; i < 10; i++) begin
      MemReady = rd[i]; #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL ldr_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL ldr_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
    checks++;
    if (ImmSrc !== 2'b01 || RegSrc !== 2'b00) begin
      failures++; $display("FAIL ldr_src imm=%b regsrc=%b exp=01/00", ImmSrc, RegSrc);
    end
  endtask

  task automatic test_str();
    logic [4:0] es [6];
    logic [7:0] em [6];
    logic       rd [6];
    es = '{5'b11100, 5'b00000, 5'b00000, 5'b10000, 5'b10010, 5'b10000};
    em = '{M_FD, M_FD, M_SUBI, M_MEM, M_MEM, M_FD};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    Instr = 20'hE5021;
    for (int i = 0; i < 6; i++) begin
      MemReady = rd[i]; #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL str_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL str_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
    checks++;
    if (RegSrc !== 2'b10) begin failures++; $display("FAIL str_regsrc got=%b exp=10", RegSrc); end
  endtask

  task automatic test_subs_branch();
    logic [4:0] es [5];
    logic [7:0] em [5];
    es = '{5'b11100, 5'b00000, 5'b00000, 5'b00001, 5'b10000};
    em = '{M_FD, M_FD, M_SUBI, M_EXR, M_FD};
    Instr = 20'hE2500; ALUFlags = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      MemReady = (i != 4); #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL subs_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL subs_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
    checks++;
    if (Flags !== 4'b0110) begin failures++; $display("FAIL subs_flags got=%b exp=0110", Flags); end
    // BEQ taken: FETCH, DECODE, BRANCH, FETCH
    Instr = 20'h0A000; ALUFlags = 4'b1001;
    es[0:3] = '{5'b11100, 5'b00000, 5'b00100, 5'b10000};
    em[0:3] = '{M_FD, M_FD, M_BR, M_FD};
    for (int i = 0; i < 4; i++) begin
      MemReady = (i != 3); #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL beq_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL beq_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
    // BNE not taken: FETCH, DECODE, FETCH
    Instr = 20'h1A000;
    es[0:2] = '{5'b11100, 5'b00000, 5'b10000};
    for (int i = 0; i < 3; i++) begin
      MemReady = (i != 2); #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL bne_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      step();
    end
    checks++;
    if (Flags !== 4'b0110) begin failures++; $display("FAIL branch_flags got=%b exp=0110", Flags); end
  endtask

  // pass_mask bit c = expected CondEx for condition code c under current Flags
  task automatic test_cond_codes(input logic [15:0] pass_mask, input string tag);
    logic [3:0] c;
    for (int k = 0; k < 16; k++) begin
      c = k[3:0];
      Instr = {c, 16'hA000};
      MemReady = 1'b1; #1;
      step();
      step();
      MemReady = 1'b0; #1;
      checks++;
      if (strb !== (pass_mask[k] ? 5'b00100 : 5'b10000)) begin
        failures++;
        $display("FAIL cond_%s code=%h got=%b exp=%b", tag, c, strb, pass_mask[k] ? 5'b00100 : 5'b10000);
      end
      if (pass_mask[k]) step();
      step();
    end
  endtask

  task automatic test_orrs();
    logic [4:0] es [5];
    logic [7:0] em [5];
    es = '{5'b11100, 5'b00000, 5'b00000, 5'b00001, 5'b10000};
    em = '{M_FD, M_FD, M_ORR, M_EXR, M_FD};
    Instr = 20'hE1990; ALUFlags = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      MemReady = (i != 4); #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL orrs_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL orrs_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
    checks++;
    if (Flags !== 4'b1010) begin failures++; $display("FAIL orrs_flags got=%b exp=1010", Flags); end
    // cmd 1010 with S=1: treated as ADD, no write, no flag update
    Instr = 20'hE1500; ALUFlags = 4'b0101;
    es[3] = 5'b00000;
    em[2] = M_EXR;
    for (int i = 0; i < 5; i++) begin
      MemReady = (i != 4); #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL unsup_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL unsup_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
    checks++;
    if (Flags !== 4'b1010) begin failures++; $display("FAIL unsup_flags got=%b exp=1010", Flags); end
  endtask

  task automatic test_pc_write();
    logic [4:0] es [6];
    logic [7:0] em [6];
    es[0:4] = '{5'b11100, 5'b00000, 5'b00000, 5'b00100, 5'b10000};
    Instr = 20'hE08F1;
    for (int i = 0; i < 5; i++) begin
      MemReady = (i != 4); #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL addpc_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      step();
    end
    es = '{5'b11100, 5'b00000, 5'b00000, 5'b10000, 5'b00100, 5'b10000};
    em = '{M_FD, M_FD, M_ADDI, M_MEM, M_MWB, M_FD};
    Instr = 20'hE59F1;
    for (int i = 0; i < 6; i++) begin
      MemReady = (i != 5); #1;
      checks++;
      if (strb !== es[i]) begin failures++; $display("FAIL ldrpc_strb cyc%0d got=%b exp=%b", i, strb, es[i]); end
      checks++;
      if (mux !== em[i]) begin failures++; $display("FAIL ldrpc_mux cyc%0d got=%h exp=%h", i, mux, em[i]); end
      step();
    end
  endtask

  task automatic test_reset_mid_store();
    Instr = 20'hE5021;
    MemReady = 1'b1; #1;
    step(); step(); step();
    MemReady = 1'b0; #1;
    checks++;
    if (strb !== 5'b10000) begin failures++; $display("FAIL rstmid_wait got=%b exp=10000", strb); end
    #2;
    MemReady = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (strb !== 5'b00000 || mux !== 8'h00) begin
      failures++; $display("FAIL rstmid_async strb=%b mux=%h expected 0/00", strb, mux);
    end
    checks++;
    if (Flags !== 4'b0000) begin failures++; $display("FAIL rstmid_flags got=%b exp=0000", Flags); end
    step();
    checks++;
    if (strb !== 5'b00000) begin failures++; $display("FAIL rstmid_held got=%b exp=00000", strb); end
    reset = 1'b1; #1;
    checks++;
    if (strb !== 5'b11100 || mux !== M_FD) begin
      failures++; $display("FAIL rstmid_fetch strb=%b mux=%h exp=11100/%h", strb, mux, M_FD);
    end
    step();
    checks++;
    if (strb !== 5'b00000 || mux !== M_FD) begin
      failures++; $display("FAIL rstmid_decode strb=%b mux=%h exp=00000/%h", strb, mux, M_FD);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_str();
    test_subs_branch();
    test_cond_codes(16'h66A5, "z");
    test_orrs();
    test_cond_codes(16'h6996, "n");
    test_pc_write();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
